// File: rtl/runway_pkg.sv
// Shared definitions for the runway signal receiver: signal word codes and
// the per-runway state type.
package runway_pkg;

  localparam logic [3:0] SIG_RWY_A   = 4'b1010;
  localparam logic [3:0] SIG_RWY_B   = 4'b1011;
  localparam logic [1:0] SIG_HOLD_PFX = 2'b11;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CLEARED  = 2'd1,
    OCCUPIED = 2'd2
  } rwy_state_e;

endpackage

// File: rtl/runway_slot.sv
// One runway: clearance/occupancy FSM, shared down-counter for the ack window
// and the occupancy period, and a saturating landing counter.
module runway_slot
  import runway_pkg::*;
#(
  parameter int OCC_CYCLES  = 16,
  parameter int ACK_TIMEOUT = 8,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_i,
  input  logic             ack_i,
  output logic             cleared_o,
  output logic             busy_o,
  output logic             expire_o,
  output logic [CNT_W-1:0] land_cnt_o
);

  localparam logic [7:0]       TMO_LOAD = 8'(ACK_TIMEOUT - 1);
  localparam logic [7:0]       OCC_LOAD = 8'(OCC_CYCLES - 1);
  localparam logic [CNT_W-1:0] LAND_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] LAND_MAX = {CNT_W{1'b1}};

  rwy_state_e       state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] land_q, land_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      land_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      land_q  <= land_d;
    end
  end

  // The counter holds the cycles remaining in the current state minus one,
  // so reaching zero marks the last cycle of the window.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    land_d   = land_q;
    expire_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_i) begin
          state_d = CLEARED;
          cnt_d   = TMO_LOAD;
        end
      end
      CLEARED: begin
        if (ack_i) begin
          state_d = OCCUPIED;
          cnt_d   = OCC_LOAD;
          if (land_q != LAND_MAX) land_d = land_q + LAND_ONE;
        end else if (cnt_q == 8'd0) begin
          state_d  = IDLE;
          expire_o = 1'b1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      OCCUPIED: begin
        if (cnt_q == 8'd0) state_d = IDLE;
        else               cnt_d   = cnt_q - 8'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  assign cleared_o  = (state_q == CLEARED);
  assign busy_o     = (state_q != IDLE);
  assign land_cnt_o = land_q;

endmodule

// File: rtl/runway_signal_receiver.sv
// Receives runway signal words, hands requests to two independent runway
// slots and produces registered deny/err/timeout pulses.
module runway_signal_receiver
  import runway_pkg::*;
#(
  parameter int OCC_CYCLES  = 16,
  parameter int ACK_TIMEOUT = 8,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sig_valid,
  input  logic [3:0]       signal,
  output logic             sig_ready,
  input  logic [1:0]       ack,
  output logic [1:0]       cleared,
  output logic [1:0]       busy,
  output logic             deny,
  output logic             err,
  output logic             timeout,
  output logic [CNT_W-1:0] land_cnt_a,
  output logic [CNT_W-1:0] land_cnt_b
);

  logic       accept, is_a, is_b, is_hold, illegal;
  logic [1:0] req, expire;
  logic       deny_q, deny_d, err_q, err_d, timeout_q, timeout_d;

  assign is_a    = (signal == SIG_RWY_A);
  assign is_b    = (signal == SIG_RWY_B);
  assign is_hold = (signal[3:2] == SIG_HOLD_PFX);
  assign illegal = !(is_a || is_b || is_hold);

  // Words are held off while any clearance is outstanding.
  assign sig_ready = !(cleared[0] || cleared[1]);
  assign accept    = sig_valid && sig_ready;

  assign req[0] = accept && is_a && !busy[0];
  assign req[1] = accept && is_b && !busy[1];

  runway_slot #(
    .OCC_CYCLES (OCC_CYCLES),
    .ACK_TIMEOUT(ACK_TIMEOUT),
    .CNT_W      (CNT_W)
  ) u_slot_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (req[0]),
    .ack_i     (ack[0]),
    .cleared_o (cleared[0]),
    .busy_o    (busy[0]),
    .expire_o  (expire[0]),
    .land_cnt_o(land_cnt_a)
  );

  runway_slot #(
    .OCC_CYCLES (OCC_CYCLES),
    .ACK_TIMEOUT(ACK_TIMEOUT),
    .CNT_W      (CNT_W)
  ) u_slot_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (req[1]),
    .ack_i     (ack[1]),
    .cleared_o (cleared[1]),
    .busy_o    (busy[1]),
    .expire_o  (expire[1]),
    .land_cnt_o(land_cnt_b)
  );

  assign deny_d    = accept && ((is_a && busy[0]) || (is_b && busy[1]));
  assign err_d     = accept && illegal;
  assign timeout_d = expire[0] || expire[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deny_q    <= 1'b0;
      err_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      deny_q    <= deny_d;
      err_q     <= err_d;
      timeout_q <= timeout_d;
    end
  end

  assign deny    = deny_q;
  assign err     = err_q;
  assign timeout = timeout_q;

endmodule
